// File: rtl/offchip_mem_model.sv
// offchip_mem_model: dual-channel byte-wide memory slave for the HLS master
// memory buses. Each channel has a latency counter and a read-data delay line.
// Optional feature macro: OFFCHIP_MEM_ERRCHK_EN adds the sticky mem_err output.
module offchip_mem_model #(
  parameter int CH_ADDR_W   = 7,
  parameter int MEMSIZE     = 32,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init_we,
  input  logic [CH_ADDR_W-1:0]   init_addr,
  input  logic [7:0]             init_data,
  input  logic [1:0]             Mout_oe_ram,
  input  logic [1:0]             Mout_we_ram,
  input  logic [2*CH_ADDR_W-1:0] Mout_addr_ram,
  input  logic [15:0]            Mout_Wdata_ram,
  input  logic [7:0]             Mout_data_ram_size,
  output logic [15:0]            M_Rdata_ram,
  output logic [1:0]             M_DataRdy
`ifdef OFFCHIP_MEM_ERRCHK_EN
  ,
  output logic                   mem_err
`endif
);

  localparam int IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int PIPE_N    = READ_DELAY - 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       mem [MEMSIZE];
  logic [1:0]       wr_en;
  logic [IDX_W-1:0] wr_idx  [2];
  logic [7:0]       wr_byte [2];
  int               init_off;
  logic             init_hit;

  // Preload address decode (absolute address to array index)
  always_comb begin
    init_off = int'(init_addr) - BASE_ADDR;
    init_hit = (init_off >= 0) && (init_off < MEMSIZE);
  end

  // Memory array: later assignments win, giving ch1 > ch0 > preload
  always_ff @(posedge clock) begin
    if (init_we && init_hit) mem[init_off[IDX_W-1:0]] <= init_data;
    if (wr_en[0]) mem[wr_idx[0]] <= wr_byte[0];
    if (wr_en[1]) mem[wr_idx[1]] <= wr_byte[1];
  end

`ifdef OFFCHIP_MEM_ERRCHK_EN
  logic [1:0] ch_err;
  logic       mem_err_q;

  // Sticky protocol error flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) mem_err_q <= 1'b0;
    else if (|ch_err) mem_err_q <= 1'b1;
  end

  assign mem_err = mem_err_q;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    int               off;
    logic             hit_l, oe_l, we_l, rd_l, issue_l;
    logic [IDX_W-1:0] idx_l;
    logic [3:0]       size_l;
    logic [7:0]       mask_l, wdata_l, old_l, rdata_l;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pipe_q [PIPE_N];

    // Channel address decode
    always_comb begin
      off = int'(Mout_addr_ram[gi*CH_ADDR_W +: CH_ADDR_W]) - BASE_ADDR;
    end

    assign hit_l   = (off >= 0) && (off < MEMSIZE);
    assign idx_l   = off[IDX_W-1:0];
    assign oe_l    = Mout_oe_ram[gi];
    assign we_l    = Mout_we_ram[gi];
    assign size_l  = Mout_data_ram_size[gi*4 +: 4];
    assign wdata_l = Mout_Wdata_ram[gi*8 +: 8];
    assign mask_l  = (size_l >= 4'd8) ? 8'hFF : 8'((9'd1 << size_l) - 9'd1);
    assign old_l   = mem[idx_l];
    assign rd_l    = hit_l && oe_l;

    // Data is captured only on the issue cycle, so the bus reads zero
    // outside the completion cycle of a request.
    assign issue_l = rd_l && (cnt_q == '0);
    assign rdata_l = issue_l ? old_l : 8'h00;

    assign wr_idx[gi]  = idx_l;
    assign wr_byte[gi] = (wdata_l & mask_l) | (old_l & ~mask_l);
`ifdef OFFCHIP_MEM_ERRCHK_EN
    assign wr_en[gi]  = hit_l && we_l && !oe_l;
    assign ch_err[gi] = (oe_l && we_l) || ((oe_l || we_l) && !hit_l);
`else
    assign wr_en[gi]  = hit_l && we_l;
`endif

    // Latency counter next state: counts while a hit request is held, wraps at its limit
    always_comb begin
      cnt_d = '0;
      if (rd_l) begin
        cnt_d = (cnt_q >= RD_LAST) ? '0 : cnt_q + CNT_ONE;
      end else if (hit_l && we_l) begin
        cnt_d = (cnt_q >= WR_LAST) ? '0 : cnt_q + CNT_ONE;
      end
    end

    // Latency counter register
    always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end

    // Read data delay line, READ_DELAY-1 stages deep
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < PIPE_N; k++) pipe_q[k] <= 8'h00;
      end else begin
        pipe_q[0] <= rdata_l;
        for (int k = 1; k < PIPE_N; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign M_Rdata_ram[gi*8 +: 8] = pipe_q[PIPE_N-1];
    assign M_DataRdy[gi] = !reset && hit_l &&
                           ((oe_l && cnt_q == RD_LAST) || (we_l && cnt_q == WR_LAST));
  end

endmodule

// File: tb/tb_offchip_mem_model.sv
// Directed testbench for offchip_mem_model: a default instance (READ_DELAY=2)
// and a READ_DELAY=3 instance sharing the same stimulus.
module tb_offchip_mem_model;
  localparam int AW = 7;

  logic            clock = 1'b0;
  logic            reset;
  logic            init_we;
  logic [AW-1:0]   init_addr;
  logic [7:0]      init_data;
  logic [1:0]      oe, we;
  logic [2*AW-1:0] addr;
  logic [15:0]     wdata;
  logic [7:0]      size;
  logic [15:0]     rdata, rdata3;
  logic [1:0]      rdy, rdy3;
`ifdef OFFCHIP_MEM_ERRCHK_EN
  logic            mem_err, mem_err3;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clock = ~clock;

  offchip_mem_model #(.CH_ADDR_W(AW), .MEMSIZE(32), .BASE_ADDR(0),
                      .READ_DELAY(2), .WRITE_DELAY(1)) u_dut (
    .clock(clock), .reset(reset), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy)
`ifdef OFFCHIP_MEM_ERRCHK_EN
    , .mem_err(mem_err)
`endif
  );

  offchip_mem_model #(.CH_ADDR_W(AW), .MEMSIZE(32), .BASE_ADDR(0),
                      .READ_DELAY(3), .WRITE_DELAY(1)) u_dut3 (
    .clock(clock), .reset(reset), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata3), .M_DataRdy(rdy3)
`ifdef OFFCHIP_MEM_ERRCHK_EN
    , .mem_err(mem_err3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    next_cycle();
    init_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("post_rst_rdy", 32'(rdy), 32'h0);
    chk("post_rst_rdata", 32'(rdata), 32'h0);
`ifdef OFFCHIP_MEM_ERRCHK_EN
    chk("post_rst_err", 32'(mem_err), 32'h0);
`endif

    // Preload; addr 5 last so the read below follows it directly
    preload(7'd3, 8'hFF);
    preload(7'd1, 8'h5A);
    preload(7'd2, 8'hC3);
    preload(7'd5, 8'hA7);

    // Channel 0 read of the preloaded byte
    oe = 2'b01; addr[6:0] = 7'd5;
    @(negedge clock);
    chk("pre_rd_t_rdy", 32'(rdy), 32'h0);
    chk("pre_rd_t_data", 32'(rdata[7:0]), 32'h0);
    next_cycle();
    @(negedge clock);
    chk("pre_rd_t1_rdy", 32'(rdy), 32'h1);
    chk("pre_rd_t1_data", 32'(rdata[7:0]), 32'hA7);
    next_cycle();
    oe = 2'b00;
    @(negedge clock);
    chk("pre_rd_t2_rdy", 32'(rdy), 32'h0);
    chk("pre_rd_t2_data", 32'(rdata[7:0]), 32'h0);

    // Masked write on channel 1: size 4 keeps the upper nibble
    next_cycle();
    we = 2'b10; addr[13:7] = 7'd3; wdata[15:8] = 8'h00; size[7:4] = 4'd4;
    @(negedge clock);
    chk("mask_wr_rdy", 32'(rdy), 32'h2);
    next_cycle();
    we = 2'b00; oe = 2'b10;
    @(negedge clock);
    chk("mask_rd_t_rdy", 32'(rdy), 32'h0);
    next_cycle();
    @(negedge clock);
    chk("mask_rd_rdy", 32'(rdy), 32'h2);
    chk("mask_rd_data", 32'(rdata[15:8]), 32'hF0);
    next_cycle();
    oe = 2'b00;

    // Both channels write addr 7 in one cycle: channel 1 wins
    we = 2'b11; addr = {7'd7, 7'd7}; wdata = 16'h2211; size = 8'h88;
    @(negedge clock);
    chk("coll_wr_rdy", 32'(rdy), 32'h3);
    next_cycle();
    we = 2'b00; oe = 2'b01;
    next_cycle();
    @(negedge clock);
    chk("coll_rd_rdy", 32'(rdy), 32'h1);
    chk("coll_rd_data", 32'(rdata[7:0]), 32'h22);

    // Read issued in the same cycle as a write to the same byte sees the old value
    next_cycle();
    we = 2'b10; wdata[15:8] = 8'h33;
    @(negedge clock);
    chk("rw_issue_rdy", 32'(rdy), 32'h2);
    next_cycle();
    we = 2'b00;
    @(negedge clock);
    chk("rw_old_rdy", 32'(rdy), 32'h1);
    chk("rw_old_data", 32'(rdata[7:0]), 32'h22);
    next_cycle();
    @(negedge clock);
    chk("rw_new_issue_rdy", 32'(rdy), 32'h0);
    next_cycle();
    @(negedge clock);
    chk("rw_new_data", 32'(rdata[7:0]), 32'h33);
    next_cycle();
    oe = 2'b00;

    // Dual read, both channels complete together
    oe = 2'b11; addr = {7'd2, 7'd1};
    @(negedge clock);
    chk("dual_t_rdy", 32'(rdy), 32'h0);
    next_cycle();
    @(negedge clock);
    chk("dual_rdy", 32'(rdy), 32'h3);
    chk("dual_data", 32'(rdata), 32'hC35A);
    next_cycle();
    oe = 2'b00;

    // Out-of-range read held for 4 cycles
    oe = 2'b01; addr[6:0] = 7'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("oob_rdy_%0d", i), 32'(rdy), 32'h0);
      chk($sformatf("oob_data_%0d", i), 32'(rdata), 32'h0);
`ifdef OFFCHIP_MEM_ERRCHK_EN
      chk($sformatf("oob_err_%0d", i), 32'(mem_err), (i == 0) ? 32'h0 : 32'h1);
`endif
      next_cycle();
    end
    oe = 2'b00;

    // READ_DELAY=3 instance: reset at cnt=1 aborts, request held through re-issue
    oe = 2'b01; addr[6:0] = 7'd5;
    @(negedge clock);
    chk("r3_t_rdy", 32'(rdy3), 32'h0);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("r3_rst_rdy", 32'(rdy3), 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("r3_reissue_rdy", 32'(rdy3), 32'h0);
`ifdef OFFCHIP_MEM_ERRCHK_EN
    chk("r3_err_cleared", 32'(mem_err), 32'h0);
`endif
    next_cycle();
    @(negedge clock);
    chk("r3_wait_rdy", 32'(rdy3), 32'h0);
    next_cycle();
    @(negedge clock);
    chk("r3_done_rdy", 32'(rdy3), 32'h1);
    chk("r3_done_data", 32'(rdata3[7:0]), 32'hA7);
    next_cycle();
    oe = 2'b00;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/offchip_mem_model.md
# offchip_mem_model

Synthesizable dual-channel off-chip memory slave that sits directly downstream of the HLS `main` master memory interface. It consumes the `Mout_*` request buses and returns `M_Rdata_ram` / `M_DataRdy` with parameterized read/write latency. It replaces the behavioural byte-array memory model in simulation benches and in FPGA-in-the-loop runs. A side port preloads memory contents before `start_port`.

## Interface
Parameters:
- `CH_ADDR_W`, 7: address width per channel lane.
- `MEMSIZE`, 32: number of byte locations.
- `BASE_ADDR`, 0: first mapped byte address.
- `READ_DELAY`, 2: read latency in cycles; must be ≥ 2.
- `WRITE_DELAY`, 1: write acknowledge latency in cycles; must be ≥ 1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init_we`  in  1  preload write strobe.
- `init_addr`  in  `CH_ADDR_W`  preload absolute address.
- `init_data`  in  8  preload byte.
- `Mout_oe_ram`  in  2  per-channel read enable; bit i is channel i.
- `Mout_we_ram`  in  2  per-channel write enable.
- `Mout_addr_ram`  in  2*`CH_ADDR_W`  per-channel address; channel i occupies `[i*CH_ADDR_W +: CH_ADDR_W]`.
- `Mout_Wdata_ram`  in  16  per-channel write byte `[i*8 +: 8]`.
- `Mout_data_ram_size`  in  8  per-channel size in bits `[i*4 +: 4]`.
- `M_Rdata_ram`  out  16  per-channel read byte.
- `M_DataRdy`  out  2  per-channel completion strobe.
- `mem_err`  out  1  sticky protocol error; present only with `OFFCHIP_MEM_ERRCHK_EN`.

## Operation
- Hit: a channel hits when `BASE_ADDR <= addr < BASE_ADDR+MEMSIZE`.
- Misses: ignored. Reads of a miss return 0. A miss never asserts `M_DataRdy`.
- Lane mask: `(1<<size)-1`, truncated to 8 bits, so size ≥ 8 gives `8'hFF`.
- Write merge: `new = (wdata & mask) | (old & ~mask)`.
- Per-channel counter `cnt[i]` (0..`READ_DELAY`-1):
  - While `oe` is high on a hit, `cnt` increments; it returns to 0 after reaching `READ_DELAY`-1.
  - While `we` is high on a hit, the same rule applies with `WRITE_DELAY`-1 as the limit.
  - Otherwise `cnt` is 0.
- `M_DataRdy[i] = hit && ((oe && cnt==READ_DELAY-1) || (we && cnt==WRITE_DELAY-1))`. This is combinational from `cnt` and the inputs.
- Read path: memory is sampled combinationally at the request address, then passed through `READ_DELAY`-1 register stages to `M_Rdata_ram`.
- Memory write timing: the write commits at the rising edge of every cycle in which `we` is high on a hit.
- Write priority when several writes target the same byte in one cycle: channel 1 > channel 0 > `init_we`.
- Read/write collision: a read sampled in the same cycle as a write to the same byte returns the old value.
- States per channel: IDLE (`cnt`=0) → BUSY (`cnt`>0) → IDLE when the strobe fires or the request drops. If the request drops mid-BUSY, the channel returns to IDLE with no strobe.

## Timing
- Reset values: `M_Rdata_ram`=0, `M_DataRdy`=0, `mem_err`=0. Counters and delay registers are cleared.
- Memory contents are not cleared by reset.
- `M_DataRdy` is forced to 0 while `reset` is high. A reset mid-request aborts the request; the master must re-issue it.
- Read latency (`READ_DELAY`=2): request at cycle t; `M_DataRdy` and valid `M_Rdata_ram` in cycle t+1.
- Write (`WRITE_DELAY`=1): `M_DataRdy` in the same cycle t; data is visible to a read issued at t+1.
- Preload: a byte written with `init_we` at cycle t is readable by a request at t+1.
- Channels are fully independent and may complete in the same cycle.

## Configuration
- `OFFCHIP_MEM_ERRCHK_EN` defined:
  - `mem_err` port exists.
  - It sets (sticky until `reset`) on `oe[i]&&we[i]` for either channel, or on any `oe`/`we` to a miss address.
  - On an `oe&&we` cycle the write is suppressed.
- Not defined:
  - No `mem_err` port and no checking logic.
  - `oe&&we` performs the write, and the counter follows the read rule.

## Test plan
- Preload: `init_we`, addr 5 = `8'hA7`; ch0 read addr 5 at t → `M_DataRdy[0]`=1 and `M_Rdata_ram[7:0]`=`8'hA7` at t+1; 0 at t and t+2.
- Masked write: mem[3]=`8'hFF`; ch1 write `8'h00` with size 4 → `M_DataRdy[1]`=1 in the same cycle; a later read returns `8'hF0`.
- Collision: same cycle, ch0 writes `8'h11` and ch1 writes `8'h22` to addr 7 → read returns `8'h22`.
- Out of range: `BASE_ADDR`=0, `MEMSIZE`=32, read addr 40 → `M_DataRdy`=0 and data 0 for 4 cycles; with the macro, `mem_err`=1 one cycle later.
- Reset mid-read: `READ_DELAY`=3, reset asserted at `cnt`=1 → no `M_DataRdy`; a re-issued read completes 2 cycles after re-issue with preserved memory data.
- Dual read: both channels read addrs 1 and 2 simultaneously → both strobes fire at t+1 with the correct bytes.
